dcache_controller: RTL and testbench
====================================

# dcache_controller

Sequencing controller for the direct-mapped, write-back data cache built around the cache access unit. It accepts one load/store at a time from the memory stage and latches the op type and byte offset that drive the access unit. It holds the tag/valid/dirty arrays, drives the data-array port, and runs writeback and refill transactions on the memory bus. It stalls the core until each access completes.

## Interface
- INDEX_BITS, 6, index width; cache holds 2^INDEX_BITS one-word lines; tag = addr[31:INDEX_BITS+2]
- clk_i  in  1  single clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-low reset
- core_req_i  in  1  access request from memory stage
- core_addr_i  in  32  byte address
- core_op_i  in  4  op code: loads 1000/1001/1010/1100/1101, stores 1011/1110/1111
- core_ready_o  out  1  request accepted this cycle when core_req_i & core_ready_o
- core_valid_o  out  1  one-cycle pulse: load data valid on access unit output
- au_op_o  out  4  latched op to access unit op_type input
- au_align_o  out  2  latched addr[1:0] to access unit addr_align input
- au_we_i  in  4  byte enables returned by access unit
- darr_addr_o  out  INDEX_BITS  data array index (synchronous read, 1-cycle)
- darr_we_o  out  4  data array byte write enables
- darr_wsel_o  out  1  write data select: 0 core normalized data, 1 mem_rdata
- mem_req_o  out  1  memory bus request
- mem_we_o  out  1  1 writeback, 0 refill read
- mem_addr_o  out  32  word-aligned memory address
- mem_ack_i  in  1  memory transaction complete

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REFILL, REPLAY.
- IDLE: core_ready_o=1. On a valid op (core_op_i[3]=1), latch addr and op, then go to LOOKUP.
  - darr_addr_o = core_addr_i index in IDLE, so read data is present in LOOKUP.
  - core_req_i with core_op_i[3]=0 is not accepted; no state change.
- LOOKUP: hit = valid[idx] & tag[idx]==latched tag.
  - Load hit: core_valid_o=1, go to IDLE.
  - Store hit: darr_we_o=au_we_i, darr_wsel_o=0, dirty[idx]=1, go to IDLE.
  - Miss with valid & dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
- WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={stored tag, idx, 2'b00}; write data is wired from the data array read port. On mem_ack_i, go to REFILL.
- REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o={latched tag, idx, 2'b00}. On mem_ack_i, in the same cycle:
  - darr_we_o=4'b1111, darr_wsel_o=1
  - tag[idx]=latched tag, valid[idx]=1, dirty[idx]=0
  - go to REPLAY
- REPLAY: darr_addr_o = idx (re-read), go to LOOKUP. The access is then guaranteed to hit.
- au_op_o/au_align_o hold the latched request from acceptance until return to IDLE.
- darr_addr_o = latched idx in all states except IDLE.

## Timing
- Reset (rst_i=0 at an edge), regardless of state:
  - state goes to IDLE; all valid and dirty bits are cleared
  - core_ready_o=1; core_valid_o, darr_we_o, mem_req_o, mem_we_o = 0
  - au_op_o=0, au_align_o=0, mem_addr_o=0
  - an in-flight memory request is dropped at the next edge; a late mem_ack_i is ignored
- Hit latency: accepted at edge N; load data valid / store write in cycle N+1; core_ready_o high again from N+2. Throughput is one access per 2 cycles.
- Clean miss: IDLE, LOOKUP, REFILL (≥1 cycle), REPLAY, LOOKUP. With ack in the first REFILL cycle, core_valid_o occurs 4 cycles after acceptance.
- Dirty miss adds ≥1 WRITEBACK cycle.
- mem_req_o, mem_we_o and mem_addr_o are held stable until mem_ack_i is sampled high. mem_req_o deasserts in the cycle after the ack unless the next state issues a new request (WRITEBACK→REFILL keeps it high with new addr/we).
- mem_ack_i is ignored when mem_req_o=0.
- core_req_i is ignored outside IDLE. The requester holds its request until accepted.
- Outputs are combinational from the state plus latched request. There are no combinational paths core_req_i→mem_*.

## Test plan
- Reset then load 1000 at 0x0000_0010: miss → REFILL with mem_addr_o=0x10 and ack after 2 cycles → core_valid_o once. A repeat load hits with core_valid_o 1 cycle after acceptance and no mem_req_o.
- Store 1011 at 0x13 after refill: darr_we_o=4'b1000 (from au_we_i) in LOOKUP, au_align_o=2'b11, dirty set. Re-read 1100 at 0x13 hits.
- Conflict: dirty line at 0x10 (INDEX_BITS=6), then load at 0x110: WRITEBACK to 0x10 with mem_we_o=1, then REFILL of 0x110 with mem_we_o=0, mem_req_o continuously high between them.
- Memory ack delayed 5 cycles: mem_addr_o and mem_we_o stable throughout, core_ready_o=0 throughout.
- Reset asserted mid-REFILL: next edge gives mem_req_o=0 and IDLE. A subsequent load to the same address misses (valid cleared). A stray mem_ack_i has no effect.
- core_req_i with op 0101 in IDLE: not accepted, no memory or array activity.

Source files
------------

// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//
// Sequencing controller for a direct-mapped, write-back data cache with
// one-word lines. It accepts one load/store at a time from the memory stage
// and latches the op and byte offset that steer the cache access unit. It
// owns the tag/valid/dirty state, drives the data-array port, and runs
// writeback and refill transactions on the memory bus. The core is stalled
// (core_ready_o low) until each access completes.
//
// Ports
//   clk_i, rst_i        clock; synchronous active-low reset
//   core_req_i          access request from the memory stage
//   core_addr_i         byte address of the access
//   core_op_i           op code (bit 3 set = valid load/store)
//   core_ready_o        request accepted when core_req_i & core_ready_o
//   core_valid_o        one-cycle pulse: load data valid on access unit output
//   au_op_o, au_align_o latched op / addr[1:0] for the access unit
//   au_we_i             byte enables returned by the access unit
//   darr_addr_o         data array index (synchronous 1-cycle read)
//   darr_we_o           data array byte write enables
//   darr_wsel_o         write data select: 0 core data, 1 mem_rdata
//   mem_req_o, mem_we_o memory bus request; 1 = writeback, 0 = refill read
//   mem_addr_o          word-aligned memory address
//   mem_ack_i           memory transaction complete
// -----------------------------------------------------------------------------
module dcache_controller #(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  core_req_i,
  input  logic [31:0]           core_addr_i,
  input  logic [3:0]            core_op_i,
  output logic                  core_ready_o,
  output logic                  core_valid_o,
  output logic [3:0]            au_op_o,
  output logic [1:0]            au_align_o,
  input  logic [3:0]            au_we_i,
  output logic [INDEX_BITS-1:0] darr_addr_o,
  output logic [3:0]            darr_we_o,
  output logic                  darr_wsel_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  input  logic                  mem_ack_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_REPLAY
  } state_t;

  state_t state_reg, state_next;

  // Latched request
  logic [31:0] addr_reg;
  logic [3:0]  op_reg;

  // Line state
  logic [LINES-1:0]    valid_reg;
  logic [LINES-1:0]    dirty_reg;
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [TAG_BITS-1:0] tag_rd_reg;

  // Decoded fields of the latched request
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  is_store;
  logic                  hit;

  // Control strobes from the FSM
  logic accept;
  logic fill_en;
  logic mark_en;

  // Per-line decode of the fill / mark-dirty strobes
  logic [LINES-1:0] fill_sel;
  logic [LINES-1:0] mark_sel;

  assign idx      = addr_reg[INDEX_BITS+1:2];
  assign req_tag  = addr_reg[31:INDEX_BITS+2];
  assign is_store = (op_reg == 4'b1011) || (op_reg == 4'b1110) || (op_reg == 4'b1111);

  // The tag array is read with the same address and latency as the data
  // array, so tag_rd_reg always corresponds to the data read port. A refill
  // writes the tag at the ack edge; the REPLAY cycle re-reads it so the
  // following LOOKUP sees the new tag and is guaranteed to hit.
  assign hit = valid_reg[idx] && (tag_rd_reg == req_tag);

  assign au_op_o    = op_reg;
  assign au_align_o = addr_reg[1:0];

  // ---------------------------------------------------------------------------
  // State register and request latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg <= core_addr_i;
        op_reg   <= core_op_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag array: write on refill, registered read at the data-array address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_mem[idx] <= req_tag;
    end
    tag_rd_reg <= tag_mem[darr_addr_o];
  end

  // ---------------------------------------------------------------------------
  // Valid / dirty bits (cleared by reset)
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      assign fill_sel[gi] = fill_en && (idx == INDEX_BITS'(gi));
      assign mark_sel[gi] = mark_en && (idx == INDEX_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      valid_reg <= valid_reg | fill_sel;
      dirty_reg <= (dirty_reg | mark_sel) & ~fill_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    fill_en      = 1'b0;
    mark_en      = 1'b0;
    core_ready_o = 1'b0;
    core_valid_o = 1'b0;
    darr_addr_o  = idx;
    darr_we_o    = 4'b0000;
    darr_wsel_o  = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'h0;

    case (state_reg)
      S_IDLE: begin
        core_ready_o = 1'b1;
        // Start the array reads with the incoming address so the line
        // is already on the read ports during LOOKUP.
        darr_addr_o  = core_addr_i[INDEX_BITS+1:2];
        if (core_req_i && core_op_i[3]) begin
          accept     = 1'b1;
          state_next = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          if (is_store) begin
            darr_we_o = au_we_i;
            mark_en   = 1'b1;
          end else begin
            core_valid_o = 1'b1;
          end
          state_next = S_IDLE;
        end else if (valid_reg[idx] && dirty_reg[idx]) begin
          state_next = S_WRITEBACK;
        end else begin
          state_next = S_REFILL;
        end
      end

      S_WRITEBACK: begin
        // Victim address uses the stored tag; write data comes straight
        // from the data array read port, which holds this line.
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_rd_reg, idx, 2'b00};
        if (mem_ack_i) begin
          state_next = S_REFILL;
        end
      end

      S_REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, idx, 2'b00};
        if (mem_ack_i) begin
          darr_we_o   = 4'b1111;
          darr_wsel_o = 1'b1;
          fill_en     = 1'b1;
          state_next  = S_REPLAY;
        end
      end

      S_REPLAY: begin
        state_next = S_LOOKUP;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_controller
//
// Drives load/store sequences into dcache_controller and acts as the memory
// bus. Expected memory transactions are queued when an access is issued and
// popped as the DUT presents each new bus request; latency, valid pulses,
// store byte enables and bus stability are compared per access.
// -----------------------------------------------------------------------------
module tb_dcache_controller;

  localparam int IB = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req;
  logic [31:0]   core_addr;
  logic [3:0]    core_op;
  logic          core_ready;
  logic          core_valid;
  logic [3:0]    au_op;
  logic [1:0]    au_align;
  logic [3:0]    au_we;
  logic [IB-1:0] darr_addr;
  logic [3:0]    darr_we;
  logic          darr_wsel;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic          mem_ack;

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] last_op = 4'h0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } txn_t;

  txn_t exp_q[$];

  always #5 clk = ~clk;

  dcache_controller #(.INDEX_BITS(IB)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .core_req_i   (core_req),
    .core_addr_i  (core_addr),
    .core_op_i    (core_op),
    .core_ready_o (core_ready),
    .core_valid_o (core_valid),
    .au_op_o      (au_op),
    .au_align_o   (au_align),
    .au_we_i      (au_we),
    .darr_addr_o  (darr_addr),
    .darr_we_o    (darr_we),
    .darr_wsel_o  (darr_wsel),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access and act as memory until the DUT returns to ready.
  // exp_valid_cyc / exp_write_cyc: cycle after acceptance in which the
  // load valid pulse / store write is expected (0 = none expected).
  task automatic do_access(input string name, input logic [31:0] a, input logic [3:0] op,
                           input logic [3:0] be, input int ack_delay,
                           input int exp_valid_cyc, input int exp_write_cyc);
    int   cyc, wait_cnt, valid_pulses, valid_cyc, write_cyc, exp_done;
    bit   done, in_txn, req_seen, last_req, req_gap;
    txn_t cur, exp;
    cyc = 0; wait_cnt = 0; valid_pulses = 0; valid_cyc = 0; write_cyc = 0;
    done = 0; in_txn = 0; req_seen = 0; last_req = 0; req_gap = 0;
    cur = '0;
    exp_done = ((exp_valid_cyc > exp_write_cyc) ? exp_valid_cyc : exp_write_cyc) + 1;

    au_we = be; core_addr = a; core_op = op; core_req = 1'b1;
    compared++;
    if (core_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s ready_at_issue: got %b want 1", name, core_ready);
    end
    tick();
    core_req = 1'b0; core_addr = 32'hDEAD_BEEF; core_op = 4'h0;
    last_op = op;
    cyc = 1;
    compared++;
    if (au_op !== op) begin
      mismatched++;
      $display("FAIL %s au_op: got %b want %b", name, au_op, op);
    end
    compared++;
    if (au_align !== a[1:0]) begin
      mismatched++;
      $display("FAIL %s au_align: got %b want %b", name, au_align, a[1:0]);
    end

    while (!done && cyc < 60) begin
      mem_ack = 1'b0;
      if (core_ready) begin
        done = 1;
      end else begin
        if (mem_req) begin
          if (req_seen && !last_req) req_gap = 1;
          req_seen = 1;
          if (!in_txn) begin
            in_txn = 1; wait_cnt = 0;
            cur = '{we: mem_we, addr: mem_addr};
            compared++;
            if (exp_q.size() == 0) begin
              mismatched++;
              $display("FAIL %s unexpected_txn: got we=%b addr=%h want none", name, mem_we, mem_addr);
            end else begin
              exp = exp_q.pop_front();
              if (cur !== exp) begin
                mismatched++;
                $display("FAIL %s txn: got we=%b addr=%h want we=%b addr=%h",
                         name, cur.we, cur.addr, exp.we, exp.addr);
              end
            end
          end else begin
            compared++;
            if (mem_we !== cur.we || mem_addr !== cur.addr) begin
              mismatched++;
              $display("FAIL %s bus_stable: got we=%b addr=%h want we=%b addr=%h",
                       name, mem_we, mem_addr, cur.we, cur.addr);
            end
          end
          wait_cnt++;
          if (wait_cnt == ack_delay) begin
            mem_ack = 1'b1;
            in_txn  = 0;
            if (!cur.we) begin
              #1;
              compared++;
              if (darr_we !== 4'b1111 || darr_wsel !== 1'b1) begin
                mismatched++;
                $display("FAIL %s refill_write: got we=%b sel=%b want 1111/1", name, darr_we, darr_wsel);
              end
            end
          end
        end
        last_req = mem_req;
        if (core_valid) begin
          valid_pulses++;
          valid_cyc = cyc;
        end
        if (darr_we != 4'b0000 && !darr_wsel) begin
          write_cyc = cyc;
          compared++;
          if (darr_we !== be) begin
            mismatched++;
            $display("FAIL %s store_be: got %b want %b", name, darr_we, be);
          end
        end
        tick();
        cyc++;
      end
    end
    mem_ack = 1'b0;

    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL %s timeout: got no ready after %0d cycles want ready", name, cyc);
    end
    compared++;
    if (cyc != exp_done) begin
      mismatched++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, exp_done);
    end
    compared++;
    if (valid_pulses != ((exp_valid_cyc > 0) ? 1 : 0) || valid_cyc != exp_valid_cyc) begin
      mismatched++;
      $display("FAIL %s valid: got %0d pulses at cyc %0d want pulse at cyc %0d",
               name, valid_pulses, valid_cyc, exp_valid_cyc);
    end
    compared++;
    if (write_cyc != exp_write_cyc) begin
      mismatched++;
      $display("FAIL %s store_cycle: got %0d want %0d", name, write_cyc, exp_write_cyc);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s missing_txn: got %0d left want 0", name, exp_q.size());
      exp_q.delete();
    end
    compared++;
    if (req_gap) begin
      mismatched++;
      $display("FAIL %s req_gap: got gap want continuous mem_req", name);
    end
    $display("%s: addr=%h op=%b done_cyc=%0d valid_cyc=%0d write_cyc=%0d",
             name, a, op, cyc, valid_cyc, write_cyc);
  endtask

  task automatic check_idle_outputs(input string name);
    compared++;
    if (core_ready !== 1'b1 || core_valid !== 1'b0 || darr_we !== 4'b0 ||
        mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
      mismatched++;
      $display("FAIL %s idle_outputs: got rdy=%b vld=%b dwe=%b req=%b we=%b addr=%h want 1 0 0000 0 0 0",
               name, core_ready, core_valid, darr_we, mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req = 1'b0; core_addr = '0; core_op = '0; au_we = '0; mem_ack = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    compared++;
    if (au_op !== 4'h0 || au_align !== 2'b00) begin
      mismatched++;
      $display("FAIL reset au: got op=%b align=%b want 0000 00", au_op, au_align);
    end
    rst_n = 1'b1;
    tick();
    check_idle_outputs("reset_release");
    $display("reset: done");
  endtask

  task automatic test_load_miss();
    exp_q.push_back('{we: 1'b0, addr: 32'h0000_0010});
    do_access("load_miss", 32'h0000_0010, 4'b1000, 4'h0, 2, 5, 0);
  endtask

  task automatic test_load_hit();
    do_access("load_hit", 32'h0000_0010, 4'b1000, 4'h0, 1, 1, 0);
  endtask

  task automatic test_store_hit();
    do_access("store_hit", 32'h0000_0013, 4'b1011, 4'b1000, 1, 0, 1);
    do_access("reread_hit", 32'h0000_0013, 4'b1100, 4'h0, 1, 1, 0);
  endtask

  task automatic test_conflict();
    exp_q.push_back('{we: 1'b1, addr: 32'h0000_0010});
    exp_q.push_back('{we: 1'b0, addr: 32'h0000_0110});
    do_access("dirty_conflict", 32'h0000_0110, 4'b1000, 4'h0, 1, 5, 0);
  endtask

  task automatic test_slow_ack();
    exp_q.push_back('{we: 1'b0, addr: 32'h0000_0400});
    do_access("slow_ack", 32'h0000_0400, 4'b1001, 4'h0, 5, 8, 0);
  endtask

  task automatic test_back_to_back();
    do_access("b2b_load_a", 32'h0000_0110, 4'b1010, 4'h0, 1, 1, 0);
    do_access("b2b_load_b", 32'h0000_0402, 4'b1101, 4'h0, 1, 1, 0);
    do_access("b2b_store", 32'h0000_0401, 4'b1110, 4'b0010, 1, 0, 1);
  endtask

  task automatic test_bad_op();
    core_req = 1'b1; core_addr = 32'h0000_0010; core_op = 4'b0101; au_we = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      check_idle_outputs("bad_op");
      tick();
    end
    core_req = 1'b0;
    compared++;
    if (au_op !== last_op) begin
      mismatched++;
      $display("FAIL bad_op au_op: got %b want %b", au_op, last_op);
    end
    $display("bad_op: op=0101 not accepted");
  endtask

  task automatic test_reset_mid_refill();
    core_req = 1'b1; core_addr = 32'h0000_0010; core_op = 4'b1000;
    tick();
    core_req = 1'b0;
    tick();
    compared++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0010) begin
      mismatched++;
      $display("FAIL mid_refill req: got req=%b we=%b addr=%h want 1 0 00000010", mem_req, mem_we, mem_addr);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_outputs("mid_refill_reset");
    compared++;
    if (au_op !== 4'h0 || au_align !== 2'b00) begin
      mismatched++;
      $display("FAIL mid_refill_reset au: got op=%b align=%b want 0000 00", au_op, au_align);
    end
    mem_ack = 1'b1;
    #1;
    check_idle_outputs("stray_ack");
    tick();
    mem_ack = 1'b0;
    check_idle_outputs("stray_ack_after");
    $display("reset_mid_refill: done");
    // Valid bits were cleared: the same line misses again, and the
    // previously dirty line at index 0 refills without a writeback.
    exp_q.push_back('{we: 1'b0, addr: 32'h0000_0010});
    do_access("post_reset_miss", 32'h0000_0010, 4'b1000, 4'h0, 1, 4, 0);
    exp_q.push_back('{we: 1'b0, addr: 32'h0000_0400});
    do_access("post_reset_clean", 32'h0000_0400, 4'b1000, 4'h0, 1, 4, 0);
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_conflict();
    test_slow_ack();
    test_back_to_back();
    test_bad_op();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
